// File: rtl/adder_serial_nbit.sv
`default_nettype none
// ============================================================================
//  Module   : adder_serial_nbit
//  Purpose  : Multi-cycle adder. Computes a + b + carry_in over BIT_WIDTH
//             bits, CHUNK_WIDTH bits per clock, LSB chunk first. A registered
//             carry links the chunks. A start/busy/done handshake frames each
//             operation.
//  Ports    : clk      - system clock, rising edge
//             n_rst    - asynchronous active-low reset
//             start    - request a new add (accepted in IDLE or DONE)
//             a, b     - BIT_WIDTH operands, latched on acceptance
//             carry_in - carry into bit 0, latched on acceptance
//             sum      - registered result, held until the next completion
//             overflow - registered flag (unsigned carry or signed overflow)
//             busy     - high while chunks are being processed
//             done     - one-cycle pulse when sum/overflow become valid
//  Revision : 1.0 - initial release
// ============================================================================
module adder_serial_nbit #(
  parameter int BIT_WIDTH   = 16,
  parameter int CHUNK_WIDTH = 4,
  parameter bit SIGNED_OVF  = 1'b0
) (
  input  logic                 clk,
  input  logic                 n_rst,
  input  logic                 start,
  input  logic [BIT_WIDTH-1:0] a,
  input  logic [BIT_WIDTH-1:0] b,
  input  logic                 carry_in,
  output logic [BIT_WIDTH-1:0] sum,
  output logic                 overflow,
  output logic                 busy,
  output logic                 done
);

  localparam int NUM_CHUNKS = BIT_WIDTH / CHUNK_WIDTH;
  localparam int CNT_W      = (NUM_CHUNKS > 1) ? $clog2(NUM_CHUNKS) : 1;
  localparam logic [CNT_W-1:0] LAST_CHUNK = CNT_W'(NUM_CHUNKS - 1);

  typedef enum logic [1:0] {
    S_IDLE = 2'd0,
    S_ADD  = 2'd1,
    S_DONE = 2'd2
  } state_t;

  state_t               state_q, state_d;
  logic [BIT_WIDTH-1:0] a_q, a_d;
  logic [BIT_WIDTH-1:0] b_q, b_d;
  logic                 carry_q, carry_d;
  logic                 a_msb_q, a_msb_d;
  logic                 b_msb_q, b_msb_d;
  logic [CNT_W-1:0]     cnt_q, cnt_d;
  logic [BIT_WIDTH-1:0] work_q, work_d;
  logic [BIT_WIDTH-1:0] sum_q, sum_d;
  logic                 ovf_q, ovf_d;

  logic [CHUNK_WIDTH:0] w_chunk_sum;
  logic [BIT_WIDTH-1:0] w_work_next;
  logic                 w_ovf_signed;
  logic                 w_accept;

  // Operand registers shift right one chunk per cycle, so the chunk being
  // added is always in the low CHUNK_WIDTH bits (no variable part-select).
  // The original sign bits are kept separately for the signed overflow test.
  assign w_chunk_sum = {1'b0, a_q[CHUNK_WIDTH-1:0]}
                     + {1'b0, b_q[CHUNK_WIDTH-1:0]}
                     + {{CHUNK_WIDTH{1'b0}}, carry_q};

  // Result chunks enter the working register from the top and shift down,
  // so after the last chunk the register holds the full sum in place.
  generate
    if (NUM_CHUNKS == 1) begin : g_single_chunk
      assign w_work_next = w_chunk_sum[CHUNK_WIDTH-1:0];
    end else begin : g_multi_chunk
      assign w_work_next = {w_chunk_sum[CHUNK_WIDTH-1:0],
                            work_q[BIT_WIDTH-1:CHUNK_WIDTH]};
    end
  endgenerate

  assign w_ovf_signed = (a_msb_q == b_msb_q) && (w_work_next[BIT_WIDTH-1] != a_msb_q);
  assign w_accept     = start && ((state_q == S_IDLE) || (state_q == S_DONE));

  always_comb begin
    state_d = state_q;
    a_d     = a_q;
    b_d     = b_q;
    carry_d = carry_q;
    a_msb_d = a_msb_q;
    b_msb_d = b_msb_q;
    cnt_d   = cnt_q;
    work_d  = work_q;
    sum_d   = sum_q;
    ovf_d   = ovf_q;

    case (state_q)
      S_ADD: begin
        a_d     = a_q >> CHUNK_WIDTH;
        b_d     = b_q >> CHUNK_WIDTH;
        carry_d = w_chunk_sum[CHUNK_WIDTH];
        work_d  = w_work_next;
        cnt_d   = cnt_q + 1'b1;
        if (cnt_q == LAST_CHUNK) begin
          sum_d   = w_work_next;
          ovf_d   = SIGNED_OVF ? w_ovf_signed : w_chunk_sum[CHUNK_WIDTH];
          cnt_d   = '0;
          state_d = S_DONE;
        end
      end
      S_DONE: begin
        state_d = S_IDLE;
      end
      default: begin
        state_d = S_IDLE;
      end
    endcase

    // Acceptance is legal from IDLE and from DONE (back-to-back operation).
    if (w_accept) begin
      a_d     = a;
      b_d     = b;
      carry_d = carry_in;
      a_msb_d = a[BIT_WIDTH-1];
      b_msb_d = b[BIT_WIDTH-1];
      cnt_d   = '0;
      state_d = S_ADD;
    end
  end

  always_ff @(posedge clk or negedge n_rst) begin
    if (!n_rst) begin
      state_q <= S_IDLE;
      a_q     <= '0;
      b_q     <= '0;
      carry_q <= 1'b0;
      a_msb_q <= 1'b0;
      b_msb_q <= 1'b0;
      cnt_q   <= '0;
      work_q  <= '0;
      sum_q   <= '0;
      ovf_q   <= 1'b0;
    end else begin
      state_q <= state_d;
      a_q     <= a_d;
      b_q     <= b_d;
      carry_q <= carry_d;
      a_msb_q <= a_msb_d;
      b_msb_q <= b_msb_d;
      cnt_q   <= cnt_d;
      work_q  <= work_d;
      sum_q   <= sum_d;
      ovf_q   <= ovf_d;
    end
  end

  assign sum      = sum_q;
  assign overflow = ovf_q;
  assign busy     = (state_q == S_ADD);
  assign done     = (state_q == S_DONE);

`ifndef SYNTHESIS
  a_no_x_on_accept : assert property (@(posedge clk) disable iff (!n_rst)
                                      w_accept |-> !$isunknown({a, b, carry_in}))
    else $error("adder_serial_nbit: X/Z on operands when start accepted");
`endif

endmodule
`default_nettype wire

// File: tb/tb_adder_serial_nbit.sv
`default_nettype none
// ============================================================================
//  Module   : tb_adder_serial_nbit
//  Purpose  : Self-checking bench for adder_serial_nbit. Three instances:
//             16/4 unsigned-overflow, 16/4 signed-overflow (both share one
//             stimulus stream), and 8/8 single-chunk.
//  Revision : 1.0 - initial release
// ============================================================================
module tb_adder_serial_nbit;

  localparam int N16 = 4;

  logic        clk;
  logic        n_rst;
  logic        start16, cin16;
  logic [15:0] a16, b16;
  logic [15:0] sum_u, sum_s;
  logic        ovf_u, ovf_s, busy_u, busy_s, done_u, done_s;
  logic        start8, cin8;
  logic [7:0]  a8, b8, sum8;
  logic        ovf8, busy8, done8;

  int checks;
  int errors;

  adder_serial_nbit #(.BIT_WIDTH(16), .CHUNK_WIDTH(4), .SIGNED_OVF(1'b0)) dut_u (
    .clk(clk), .n_rst(n_rst), .start(start16), .a(a16), .b(b16), .carry_in(cin16),
    .sum(sum_u), .overflow(ovf_u), .busy(busy_u), .done(done_u));

  adder_serial_nbit #(.BIT_WIDTH(16), .CHUNK_WIDTH(4), .SIGNED_OVF(1'b1)) dut_s (
    .clk(clk), .n_rst(n_rst), .start(start16), .a(a16), .b(b16), .carry_in(cin16),
    .sum(sum_s), .overflow(ovf_s), .busy(busy_s), .done(done_s));

  adder_serial_nbit #(.BIT_WIDTH(8), .CHUNK_WIDTH(8), .SIGNED_OVF(1'b0)) dut_d (
    .clk(clk), .n_rst(n_rst), .start(start8), .a(a8), .b(b8), .carry_in(cin8),
    .sum(sum8), .overflow(ovf8), .busy(busy8), .done(done8));

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // ---------------- reference model (plain integer arithmetic) -------------
  function automatic logic [15:0] m_sum16(logic [15:0] x, logic [15:0] y, logic c);
    int t;
    t = int'(x) + int'(y) + int'(c);
    return t[15:0];
  endfunction

  function automatic logic m_uovf16(logic [15:0] x, logic [15:0] y, logic c);
    return (int'(x) + int'(y) + int'(c)) > 65535;
  endfunction

  function automatic logic m_sovf16(logic [15:0] x, logic [15:0] y, logic c);
    int sx, sy, s;
    sx = $signed(x);
    sy = $signed(y);
    s  = sx + sy + int'(c);
    return (s > 32767) || (s < -32768);
  endfunction

  // ---------------- stimulus helper (no checking inside) -------------------
  // Returns at the negedge where done was seen; lat counts negedges after the
  // accepting edge (done after edge E0+N gives lat = N).
  task automatic run16(input logic [15:0] ta, input logic [15:0] tb, input logic tc,
                       output int lat, output int nbusy);
    @(negedge clk);
    a16 = ta; b16 = tb; cin16 = tc; start16 = 1'b1;
    @(negedge clk);
    start16 = 1'b0;
    lat = -1; nbusy = 0;
    for (int k = 0; k < N16 + 4; k++) begin
      if (done_u) begin
        lat = k;
        break;
      end
      if (busy_u) nbusy++;
      @(negedge clk);
    end
  endtask

  // ---------------- tests ---------------------------------------------------
  task automatic test_reset;
    int lat, nbusy, ndone, nz;
    n_rst = 1'b0;
    #12;
    checks++; if (sum_u !== 16'h0000) begin errors++; $display("FAIL reset_sum: got %h expected %h", sum_u, 16'h0); end
    checks++; if ({ovf_u, busy_u, done_u} !== 3'b000) begin errors++; $display("FAIL reset_flags: got %b expected 000", {ovf_u, busy_u, done_u}); end
    @(negedge clk);
    n_rst = 1'b1;
    // complete one op so sum is nonzero, then abort the next one mid-flight
    run16(16'hF00F, 16'h0FF1, 1'b1, lat, nbusy);
    @(negedge clk);
    a16 = 16'h1234; b16 = 16'h4321; cin16 = 1'b0; start16 = 1'b1;
    @(negedge clk);
    start16 = 1'b0;
    @(negedge clk);
    #2 n_rst = 1'b0;
    #1;
    checks++; if (sum_u !== 16'h0000) begin errors++; $display("FAIL async_reset_sum: got %h expected %h", sum_u, 16'h0); end
    checks++; if ({ovf_u, busy_u, done_u} !== 3'b000) begin errors++; $display("FAIL async_reset_flags: got %b expected 000", {ovf_u, busy_u, done_u}); end
    checks++; if ({sum_s, busy_s} !== 17'h0) begin errors++; $display("FAIL async_reset_signed: got %h expected 0", {sum_s, busy_s}); end
    @(negedge clk);
    n_rst = 1'b1;
    ndone = 0; nz = 0;
    for (int k = 0; k < N16 + 3; k++) begin
      @(negedge clk);
      if (done_u || done_s) ndone++;
      if (sum_u !== 16'h0 || busy_u) nz++;
    end
    checks++; if (ndone !== 0) begin errors++; $display("FAIL reset_no_done: got %0d pulses expected 0", ndone); end
    checks++; if (nz !== 0) begin errors++; $display("FAIL reset_stays_idle: got %0d bad cycles expected 0", nz); end
  endtask

  task automatic test_unsigned_basic;
    int lat, nbusy;
    run16(16'h1234, 16'h1111, 1'b0, lat, nbusy);
    checks++; if (lat !== N16) begin errors++; $display("FAIL basic_latency: got %0d expected %0d", lat, N16); end
    checks++; if (nbusy !== N16) begin errors++; $display("FAIL basic_busy_cycles: got %0d expected %0d", nbusy, N16); end
    checks++; if (sum_u !== 16'h2345) begin errors++; $display("FAIL basic_sum: got %h expected %h", sum_u, 16'h2345); end
    checks++; if (ovf_u !== 1'b0) begin errors++; $display("FAIL basic_ovf: got %b expected 0", ovf_u); end
    checks++; if (busy_u !== 1'b0) begin errors++; $display("FAIL basic_busy_in_done: got %b expected 0", busy_u); end
    @(negedge clk);
    checks++; if (done_u !== 1'b0) begin errors++; $display("FAIL basic_done_width: got %b expected 0", done_u); end
    checks++; if (sum_u !== 16'h2345) begin errors++; $display("FAIL basic_sum_hold: got %h expected %h", sum_u, 16'h2345); end
  endtask

  task automatic test_wrap;
    int lat, nbusy;
    run16(16'hFFFF, 16'h0000, 1'b1, lat, nbusy);
    checks++; if (lat !== N16) begin errors++; $display("FAIL wrap_latency: got %0d expected %0d", lat, N16); end
    checks++; if (sum_u !== 16'h0000) begin errors++; $display("FAIL wrap_sum: got %h expected %h", sum_u, 16'h0); end
    checks++; if (ovf_u !== 1'b1) begin errors++; $display("FAIL wrap_uovf: got %b expected 1", ovf_u); end
    checks++; if (ovf_s !== 1'b0) begin errors++; $display("FAIL wrap_sovf: got %b expected 0", ovf_s); end
  endtask

  task automatic test_signed;
    int lat, nbusy;
    run16(16'h7FFF, 16'h0001, 1'b0, lat, nbusy);
    checks++; if (done_s !== 1'b1) begin errors++; $display("FAIL signed1_done: got %b expected 1", done_s); end
    checks++; if (sum_s !== 16'h8000) begin errors++; $display("FAIL signed1_sum: got %h expected %h", sum_s, 16'h8000); end
    checks++; if (ovf_s !== 1'b1) begin errors++; $display("FAIL signed1_sovf: got %b expected 1", ovf_s); end
    checks++; if (ovf_u !== 1'b0) begin errors++; $display("FAIL signed1_uovf: got %b expected 0", ovf_u); end
    run16(16'hFFFF, 16'h0001, 1'b0, lat, nbusy);
    checks++; if (sum_s !== 16'h0000) begin errors++; $display("FAIL signed2_sum: got %h expected %h", sum_s, 16'h0); end
    checks++; if (ovf_s !== 1'b0) begin errors++; $display("FAIL signed2_sovf: got %b expected 0", ovf_s); end
    checks++; if (ovf_u !== 1'b1) begin errors++; $display("FAIL signed2_uovf: got %b expected 1", ovf_u); end
  endtask

  task automatic test_ignore_start;
    logic [15:0] x, y, got;
    logic c;
    int ndone, lat;
    x = 16'($urandom); y = 16'($urandom); c = 1'($urandom);
    @(negedge clk);
    a16 = x; b16 = y; cin16 = c; start16 = 1'b1;
    @(negedge clk);
    start16 = 1'b0;
    ndone = 0; lat = -1; got = '0;
    for (int k = 0; k < N16 + 6; k++) begin
      if (k == 1) begin a16 = ~x; b16 = y ^ 16'h5A5A; cin16 = ~c; start16 = 1'b1; end
      if (k == 2) begin a16 = 16'($urandom); start16 = 1'b0; end
      if (done_u) begin
        ndone++;
        if (lat < 0) begin lat = k; got = sum_u; end
      end
      @(negedge clk);
    end
    checks++; if (ndone !== 1) begin errors++; $display("FAIL ignore_done_count: got %0d expected 1", ndone); end
    checks++; if (lat !== N16) begin errors++; $display("FAIL ignore_latency: got %0d expected %0d", lat, N16); end
    checks++; if (got !== m_sum16(x, y, c)) begin errors++; $display("FAIL ignore_sum: got %h expected %h", got, m_sum16(x, y, c)); end
  endtask

  task automatic test_back_to_back;
    logic [15:0] x1, y1, x2, y2, exp1, got;
    logic c1, c2;
    int lat, nbusy, held_bad;
    x1 = 16'($urandom); y1 = 16'($urandom); c1 = 1'($urandom);
    x2 = 16'($urandom); y2 = 16'($urandom); c2 = 1'($urandom);
    exp1 = m_sum16(x1, y1, c1);
    run16(x1, y1, c1, lat, nbusy);
    checks++; if (sum_u !== exp1) begin errors++; $display("FAIL b2b_first_sum: got %h expected %h", sum_u, exp1); end
    a16 = x2; b16 = y2; cin16 = c2; start16 = 1'b1;
    @(negedge clk);
    start16 = 1'b0;
    held_bad = 0; lat = -1; got = '0;
    for (int k = 0; k < N16 + 4; k++) begin
      if (done_u) begin lat = k; got = sum_u; break; end
      if (sum_u !== exp1) held_bad++;
      @(negedge clk);
    end
    checks++; if (held_bad !== 0) begin errors++; $display("FAIL b2b_sum_hold: got %0d changed cycles expected 0", held_bad); end
    checks++; if (lat !== N16) begin errors++; $display("FAIL b2b_latency: got %0d expected %0d", lat, N16); end
    checks++; if (got !== m_sum16(x2, y2, c2)) begin errors++; $display("FAIL b2b_second_sum: got %h expected %h", got, m_sum16(x2, y2, c2)); end
    checks++; if (ovf_s !== m_sovf16(x2, y2, c2)) begin errors++; $display("FAIL b2b_second_sovf: got %b expected %b", ovf_s, m_sovf16(x2, y2, c2)); end
  endtask

  task automatic test_random;
    logic [15:0] x, y;
    logic c;
    int lat, nbusy;
    for (int i = 0; i < 24; i++) begin
      x = 16'($urandom); y = 16'($urandom); c = 1'($urandom);
      if (i == 0) begin x = 16'h8000; y = 16'h8000; c = 1'b1; end
      if (i == 1) begin x = 16'h0FFF; y = 16'h0001; c = 1'b0; end
      run16(x, y, c, lat, nbusy);
      checks++; if (lat !== N16) begin errors++; $display("FAIL rand_latency[%0d]: got %0d expected %0d", i, lat, N16); end
      checks++; if (sum_u !== m_sum16(x, y, c)) begin errors++; $display("FAIL rand_sum[%0d]: got %h expected %h", i, sum_u, m_sum16(x, y, c)); end
      checks++; if (ovf_u !== m_uovf16(x, y, c)) begin errors++; $display("FAIL rand_uovf[%0d]: got %b expected %b", i, ovf_u, m_uovf16(x, y, c)); end
      checks++; if (sum_s !== m_sum16(x, y, c)) begin errors++; $display("FAIL rand_sum_s[%0d]: got %h expected %h", i, sum_s, m_sum16(x, y, c)); end
      checks++; if (ovf_s !== m_sovf16(x, y, c)) begin errors++; $display("FAIL rand_sovf[%0d]: got %b expected %b", i, ovf_s, m_sovf16(x, y, c)); end
    end
  endtask

  task automatic test_degenerate;
    logic [7:0] x, y;
    logic c;
    int lat, t;
    for (int i = 0; i < 8; i++) begin
      x = 8'($urandom); y = 8'($urandom); c = 1'($urandom);
      if (i == 0) begin x = 8'hC8; y = 8'h64; c = 1'b0; end
      t = int'(x) + int'(y) + int'(c);
      @(negedge clk);
      a8 = x; b8 = y; cin8 = c; start8 = 1'b1;
      @(negedge clk);
      start8 = 1'b0;
      lat = -1;
      for (int k = 0; k < 4; k++) begin
        if (done8) begin lat = k; break; end
        @(negedge clk);
      end
      checks++; if (lat !== 1) begin errors++; $display("FAIL deg_latency[%0d]: got %0d expected 1", i, lat); end
      checks++; if (sum8 !== t[7:0]) begin errors++; $display("FAIL deg_sum[%0d]: got %h expected %h", i, sum8, t[7:0]); end
      checks++; if (ovf8 !== (t > 255)) begin errors++; $display("FAIL deg_ovf[%0d]: got %b expected %b", i, ovf8, (t > 255)); end
    end
  endtask

  initial begin
    checks = 0; errors = 0;
    start16 = 1'b0; a16 = '0; b16 = '0; cin16 = 1'b0;
    start8  = 1'b0; a8  = '0; b8  = '0; cin8  = 1'b0;
    test_reset();
    test_unsigned_basic();
    test_wrap();
    test_signed();
    test_ignore_start();
    test_back_to_back();
    test_random();
    test_degenerate();
    repeat (2) @(negedge clk);
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
`default_nettype wire
